lpgbt_uplink_capture: RTL

LPGBT_UPLINK_CAPTURE -- requirements
Module: lpgbt_uplink_capture

---
 rtl/lpgbt_uplink_capture_if.sv | 11 +
 rtl/lpgbt_uplink_capture.sv | 134 +++++++++++++
 2 files changed

// File: rtl/lpgbt_uplink_capture_if.sv
// Readout stream of the lpGBT uplink capture block: 32-bit words with valid/ready
// handshake and a last marker on the final word of each frame.
interface lpgbt_uplink_capture_if;
  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        m_last_o;
  logic        m_ready_i;

  modport master (output m_data_o, output m_valid_o, output m_last_o, input m_ready_i);
  modport slave  (input m_data_o, input m_valid_o, input m_last_o, output m_ready_i);
endinterface

// File: rtl/lpgbt_uplink_capture.sv
// Captures a programmed number of decoded lpGBT uplink frames into a frame buffer
// and streams each stored frame out as eight 32-bit words.
module lpgbt_uplink_capture #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk40,
  input  logic                  rst,
  input  logic                  uplinkrdy_i,
  input  logic [233:0]          uplinkUserData_i,
  input  logic                  uplinkFEC_i,
  input  logic                  arm_i,
  input  logic                  clear_i,
  input  logic [15:0]           num_frames_i,
  lpgbt_uplink_capture_if.master rd,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic                  lostlock_o,
  output logic [15:0]           frames_captured_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, CAPTURE, DONE} state_t;

  state_t        state;
  logic [15:0]   num_frames_q;
  logic [15:0]   frames_seen;
  logic [15:0]   frames_captured;
  logic          overflow;
  logic          lostlock;
  logic [234:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [2:0]    word_idx;

  logic          full;
  logic          frame_in;
  logic          wr_en;
  logic          xfer;
  logic          pop;
  logic          last_frame;
  logic [255:0]  frame_words;

  always_comb begin
    full       = (count == DEPTH_CNT);
    frame_in   = uplinkrdy_i && ((state == WAIT_RDY) || (state == CAPTURE));
    wr_en      = frame_in && !full;
    xfer       = rd.m_valid_o && rd.m_ready_i;
    pop        = xfer && (word_idx == 3'd7);
    last_frame = ((frames_seen + 16'd1) == num_frames_q);
  end

  // Word 7 carries the FEC flag above the top ten data bits, zero-padded.
  assign frame_words  = {21'b0, mem[rd_ptr]};
  assign rd.m_valid_o = (count != '0);
  assign rd.m_data_o  = rd.m_valid_o ? frame_words[{word_idx, 5'd0} +: 32] : 32'd0;
  assign rd.m_last_o  = rd.m_valid_o && (word_idx == 3'd7);

  assign busy_o            = (state == WAIT_RDY) || (state == CAPTURE);
  assign done_o            = (state == DONE);
  assign overflow_o        = overflow;
  assign lostlock_o        = lostlock;
  assign frames_captured_o = frames_captured;

  always_ff @(posedge clk40) begin
    if (wr_en) begin
      mem[wr_ptr] <= {uplinkFEC_i, uplinkUserData_i};
    end
  end

  always_ff @(posedge clk40) begin
    if (rst || clear_i) begin
      state           <= IDLE;
      num_frames_q    <= 16'd0;
      frames_seen     <= 16'd0;
      frames_captured <= 16'd0;
      overflow        <= 1'b0;
      lostlock        <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      word_idx        <= 3'd0;
    end else begin
      if (xfer) begin
        word_idx <= word_idx + 3'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en) begin
        wr_ptr          <= wr_ptr + AW'(1);
        frames_captured <= frames_captured + 16'd1;
      end
      if (wr_en && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !wr_en) begin
        count <= count - (AW+1)'(1);
      end
      // A frame seen while full is dropped but still counts toward the run length.
      if (frame_in) begin
        frames_seen <= frames_seen + 16'd1;
        if (full) begin
          overflow <= 1'b1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (arm_i) begin
            num_frames_q    <= num_frames_i;
            frames_seen     <= 16'd0;
            frames_captured <= 16'd0;
            overflow        <= 1'b0;
            lostlock        <= 1'b0;
            state           <= (num_frames_i == 16'd0) ? DONE : WAIT_RDY;
          end
        end
        WAIT_RDY, CAPTURE: begin
          if (uplinkrdy_i) begin
            state <= last_frame ? DONE : CAPTURE;
          end else if (state == CAPTURE) begin
            lostlock <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
